// File: rtl/rx_gearbox_pkg.sv
// Shared constants and types for the 32:66 RX gearbox and block_sync.
// Optional block counter output is enabled by defining RX_GEARBOX_STATS_EN.
package rx_gbox_pkg;
  localparam int DIN_W   = 32;
  localparam int BLK_W   = 66;
  localparam int BUF_W   = 193;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = 32;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef logic [BLK_W-1:0] blk_t;
  typedef logic [BUF_W-1:0] gbox_buf_t;
endpackage

// File: rtl/rx_gearbox_if.sv
// Bus between the deserialiser side, the gearbox and block_sync.
// blk_cnt_o exists only when RX_GEARBOX_STATS_EN is defined.
interface rx_gearbox_if;
  import rx_gbox_pkg::*;

  // data_valid_i qualifies data_i on each clock with no backpressure (no ready);
  // block_valid_o is a one-cycle pulse qualifying block_o.
  logic [DIN_W-1:0] data_i;
  logic             data_valid_i;
  logic [7:0]       block_offset_i;
  gbox_buf_t        gbox_buffer_o;
  logic [CNT_W-1:0] gbox_cnt_o;
  blk_t             block_o;
  logic             block_valid_o;
`ifdef RX_GEARBOX_STATS_EN
  logic [31:0]      blk_cnt_o;
`endif

  modport master (
    output data_i, data_valid_i, block_offset_i,
    input  gbox_buffer_o, gbox_cnt_o, block_o, block_valid_o
`ifdef RX_GEARBOX_STATS_EN
    , input blk_cnt_o
`endif
  );

  modport slave (
    input  data_i, data_valid_i, block_offset_i,
    output gbox_buffer_o, gbox_cnt_o, block_o, block_valid_o
`ifdef RX_GEARBOX_STATS_EN
    , output blk_cnt_o
`endif
  );
endinterface

// File: rtl/rx_gearbox_extract.sv
// Combinational block cutter: picks the 66-bit block sitting 'off' bits below
// the oldest unconsumed bit of the updated window, and flags whether it is complete.
module gbox_extract
  import rx_gbox_pkg::*;
(
  input  gbox_buf_t  win_n_i,
  input  logic [7:0] fill_n_i,
  input  logic [6:0] off_i,
  output blk_t       blk_o,
  output logic       emit_o
);
  logic [8:0] avail;
  logic [7:0] lo;
  gbox_buf_t  shifted;

  always_comb begin
    avail   = {1'b0, fill_n_i} - {2'b00, off_i};
    // avail[8] set means the offset reaches past the fill region
    emit_o  = !avail[8] && (avail >= 9'(BLK_W));
    lo      = emit_o ? (avail[7:0] - 8'(BLK_W)) : 8'd0;
    shifted = win_n_i >> lo;
    blk_o   = shifted[BLK_W-1:0];
  end
endmodule

// File: rtl/rx_gearbox.sv
// 32:66 receive gearbox: shifts words into a 193-bit history window and cuts
// aligned 66-bit blocks at block_offset_i. RX_GEARBOX_STATS_EN adds blk_cnt_o.
module rx_gearbox
  import rx_gbox_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  rx_gearbox_if.slave  gbox
);
  gbox_buf_t        win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fill_q, fill_d;
  blk_t             block_q, slice;
  logic             block_valid_q;
  logic             emit;
  logic [6:0]       off;
`ifdef RX_GEARBOX_STATS_EN
  logic [31:0]      blk_cnt_q;
`endif

  always_comb begin
    win_d  = {win_q[BUF_W-DIN_W-1:0], gbox.data_i};
    fill_d = fill_q + 8'(DIN_W);
    cnt_d  = (cnt_q == CNT_W'(CNT_MAX)) ? '0 : cnt_q + 1'b1;
    off    = (gbox.block_offset_i > 8'(BLK_W-1)) ? 7'(BLK_W-1) : gbox.block_offset_i[6:0];
  end

  gbox_extract u_extract (
    .win_n_i  (win_d),
    .fill_n_i (fill_d),
    .off_i    (off),
    .blk_o    (slice),
    .emit_o   (emit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q         <= '0;
      cnt_q         <= '0;
      fill_q        <= '0;
      block_q       <= '0;
      block_valid_q <= 1'b0;
`ifdef RX_GEARBOX_STATS_EN
      blk_cnt_q     <= '0;
`endif
    end else begin
      block_valid_q <= 1'b0;
      if (gbox.data_valid_i) begin
        win_q <= win_d;
        cnt_q <= cnt_d;
        if (emit) begin
          // Only the 66 emitted bits are consumed; the offset lead stays skipped.
          block_q       <= slice;
          block_valid_q <= 1'b1;
          fill_q        <= fill_d - 8'(BLK_W);
`ifdef RX_GEARBOX_STATS_EN
          blk_cnt_q     <= blk_cnt_q + 32'd1;
`endif
        end else begin
          fill_q <= fill_d;
        end
      end
    end
  end

  assign gbox.gbox_buffer_o = win_q;
  assign gbox.gbox_cnt_o    = cnt_q;
  assign gbox.block_o       = block_q;
  assign gbox.block_valid_o = block_valid_q;
`ifdef RX_GEARBOX_STATS_EN
  assign gbox.blk_cnt_o     = blk_cnt_q;
`endif
endmodule

// File: tb/tb_rx_gearbox.sv
// Bench for rx_gearbox: drives a 16-block reference bit stream as 32-bit words
// and checks emitted blocks through an expected-block queue.
module tb_rx_gearbox;
  import rx_gbox_pkg::*;

  logic clk = 1'b0;
  logic rst;
  rx_gearbox_if bus ();

  rx_gearbox dut (
    .clk_i (clk),
    .rst_i (rst),
    .gbox  (bus)
  );

  always #5 clk = ~clk;

  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;
  blk_t exp_q[$];
  blk_t mon_exp;

  // Reference stream: block k = {01, A5A5_0000_0000_0000 + k}, bit 65 sent first.
  function automatic logic sbit(input int p);
    blk_t b;
    b = {SYNC_DATA, 64'hA5A5_0000_0000_0000 + 64'(p / 66)};
    return b[65 - (p % 66)];
  endfunction

  function automatic logic [31:0] word_at(input int j);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[31-b] = sbit(32*j + b);
    return w;
  endfunction

  function automatic blk_t blk_at(input int p);
    blk_t r;
    for (int b = 0; b < 66; b++) r[65-b] = sbit(p + b);
    return r;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [192:0] act, input logic [192:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input int j, input logic [7:0] off);
    bus.data_i         = word_at(j);
    bus.data_valid_i   = 1'b1;
    bus.block_offset_i = off;
    @(posedge clk);
    #1;
    bus.data_valid_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.data_valid_i = 1'b0;
    bus.data_i       = $urandom_range(32'hFFFF_FFFF, 0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.data_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pulses = 0;
  endtask

  task automatic push_std(input int off, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(blk_at(off + 66*k));
  endtask

  task automatic expect_end(input string name, input int n);
    idle(3);
    check_int({name, "_pulses"}, pulses, n);
    check_int({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    check_vec({name, "_buf"}, bus.gbox_buffer_o, '0);
    check_int({name, "_cnt"}, int'(bus.gbox_cnt_o), 0);
    check_vec({name, "_blk"}, 193'(bus.block_o), '0);
    check_int({name, "_vld"}, int'(bus.block_valid_o), 0);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.block_valid_o === 1'b1) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_block: got %h expected none", bus.block_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.block_o !== mon_exp) begin
          bad++;
          $display("FAIL block: got %h expected %h", bus.block_o, mon_exp);
        end
      end
    end
  end

  initial begin
    bus.data_i         = '0;
    bus.data_valid_i   = 1'b0;
    bus.block_offset_i = 8'd0;

    // Reset state and idle hold
    do_reset();
    check_zero("t1_rst");
`ifdef RX_GEARBOX_STATS_EN
    check_int("t1_blk_cnt", int'(bus.blk_cnt_o), 0);
`endif
    idle(3);
    check_zero("t1_idle");

    // Continuous stream, offset 0
    push_std(0, 16);
    for (int j = 0; j < 33; j++) begin
      send_word(j, 8'd0);
      check_int("t2_cnt", int'(bus.gbox_cnt_o), (j + 1) % 33);
    end
    expect_end("t2", 16);

    // Same stream with gaps; leftover fill must be zero for this to line up
    pulses = 0;
    push_std(0, 16);
    for (int j = 0; j < 33; j++) begin
      send_word(j, 8'd0);
      idle(1);
      check_int("t3_gap_vld", int'(bus.block_valid_o), 0);
      check_int("t3_gap_cnt", int'(bus.gbox_cnt_o), (j + 1) % 33);
    end
    expect_end("t3", 16);

    // Offset 5: first block after the third word, blocks at 5 + 66k
    do_reset();
    push_std(5, 15);
    for (int j = 0; j < 33; j++) begin
      send_word(j, 8'd5);
      if (j == 1) check_int("t4_no_early", int'(bus.block_valid_o), 0);
      if (j == 2) check_int("t4_first", int'(bus.block_valid_o), 1);
    end
    expect_end("t4", 15);

    // Offset 200 saturates to 65
    do_reset();
    push_std(65, 15);
    for (int j = 0; j < 33; j++) send_word(j, 8'd200);
    expect_end("t4_sat", 15);

    // Offset 0 -> 3 after four blocks, then back to 0 after the fifth
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(blk_at(66*k));
    exp_q.push_back(blk_at(267));
    for (int k = 5; k < 16; k++) exp_q.push_back(blk_at(66*k));
    for (int j = 0; j < 33; j++) send_word(j, (j == 9 || j == 10) ? 8'd3 : 8'd0);
    expect_end("t5", 16);

    // Reset collides with a valid word mid-stream
    do_reset();
    push_std(0, 16);
    for (int j = 0; j < 5; j++) send_word(j, 8'd0);
    rst              = 1'b1;
    bus.data_i       = word_at(5);
    bus.data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    check_int("t6_before_rst", exp_q.size(), 14);
    check_zero("t6_rst");
`ifdef RX_GEARBOX_STATS_EN
    check_int("t6_blk_cnt_rst", int'(bus.blk_cnt_o), 0);
`endif
    rst              = 1'b0;
    bus.data_valid_i = 1'b0;
    exp_q.delete();
    pulses = 0;
    push_std(0, 16);
    for (int j = 0; j < 33; j++) send_word(j, 8'd0);
    expect_end("t6", 16);
`ifdef RX_GEARBOX_STATS_EN
    check_int("t6_blk_cnt", int'(bus.blk_cnt_o), 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
